// File: rtl/al_axil_bridge.sv
// AL-to-AXI4-Lite master bridge: a single-outstanding write FSM, a credit-limited
// pipelined read path with a first-word fall-through response FIFO, and saturating error counters.
module al_axil_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int NB        = DATA_WIDTH / 8,
    localparam int LSB       = $clog2(NB)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // AXI-Lite master side
    output logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    output logic                      s_axi_awvalid,
    input  logic                      s_axi_awready,
    output logic [DATA_WIDTH-1:0]     s_axi_wdata,
    output logic [NB-1:0]             s_axi_wstrb,
    output logic                      s_axi_wvalid,
    input  logic                      s_axi_wready,
    input  logic [1:0]                s_axi_bresp,
    input  logic                      s_axi_bvalid,
    output logic                      s_axi_bready,
    output logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    output logic                      s_axi_arvalid,
    input  logic                      s_axi_arready,
    input  logic [DATA_WIDTH-1:0]     s_axi_rdata,
    input  logic [1:0]                s_axi_rresp,
    input  logic                      s_axi_rvalid,
    output logic                      s_axi_rready,
    // AL initiator side (word addresses)
    input  logic [ADDR_WIDTH-LSB-1:0] m_al_waddr,
    input  logic [DATA_WIDTH-1:0]     m_al_wdata,
    input  logic [NB-1:0]             m_al_wstrb,
    input  logic                      m_al_wvalid,
    output logic                      m_al_wready,
    output logic [1:0]                m_al_bresp,
    output logic                      m_al_bvalid,
    input  logic                      m_al_bready,
    input  logic [ADDR_WIDTH-LSB-1:0] m_al_araddr,
    input  logic                      m_al_arvalid,
    output logic                      m_al_arready,
    output logic [DATA_WIDTH-1:0]     m_al_rdata,
    output logic [1:0]                m_al_rresp,
    output logic                      m_al_rvalid,
    input  logic                      m_al_rready,
    output logic [15:0]               wr_err_cnt,
    output logic [15:0]               rd_err_cnt,
    output logic [1:0]                dbg_w_state_o
);
    // Every channel is valid/ready: a transfer happens on a rising clk edge where both are high,
    // and a source holds its payload stable while valid is high and ready is low.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ISSUE = 2'd1, W_RESP = 2'd2, W_ACK = 2'd3} w_state_e;

    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [15:0]           wr_err_q, wr_err_d;

    always_comb begin
        w_state_d    = w_state_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        wr_err_d     = wr_err_q;
        m_al_wready  = 1'b0;
        s_axi_bready = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                m_al_wready = 1'b1;
                if (m_al_wvalid) begin
                    awaddr_d  = {m_al_waddr, {LSB{1'b0}}};
                    wdata_d   = m_al_wdata;
                    wstrb_d   = m_al_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    w_state_d = W_ISSUE;
                end
            end
            W_ISSUE: begin
                // Address and data handshake independently, in any order.
                if (s_axi_awready) awvalid_d = 1'b0;
                if (s_axi_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) w_state_d = W_RESP;
            end
            W_RESP: begin
                s_axi_bready = 1'b1;
                if (s_axi_bvalid) begin
                    bresp_d   = s_axi_bresp;
                    bvalid_d  = 1'b1;
                    w_state_d = W_ACK;
                    if (s_axi_bresp != 2'b00 && wr_err_q != 16'hFFFF) wr_err_d = wr_err_q + 16'd1;
                end
            end
            W_ACK: begin
                if (m_al_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '1;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            wr_err_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign s_axi_awaddr  = awaddr_q;
    assign s_axi_awvalid = awvalid_q;
    assign s_axi_wdata   = wdata_q;
    assign s_axi_wstrb   = wstrb_q;
    assign s_axi_wvalid  = wvalid_q;
    assign m_al_bresp    = bresp_q;
    assign m_al_bvalid   = bvalid_q;
    assign wr_err_cnt    = wr_err_q;
    assign dbg_w_state_o = w_state_q;

    // Read path: cred counts AL reads not yet popped, cnt counts responses sitting in the FIFO.
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic [CW-1:0]         cred_q, cred_d, cnt_q, cnt_d;
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [15:0]           rd_err_q, rd_err_d;
    logic [DATA_WIDTH+1:0] mem_q [DEPTH];
    logic                  ar_hs, r_pop, r_push;

    assign m_al_arready = (cred_q < DEPTH_C) && (!arvalid_q || s_axi_arready);
    assign ar_hs        = m_al_arvalid && m_al_arready;
    assign r_pop        = (cnt_q != '0) && m_al_rready;
    // A response is only taken when a read is actually outstanding, so stale
    // responses arriving after a reset are dropped.
    assign r_push       = s_axi_rvalid && (cred_q != cnt_q);

    always_comb begin
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        cred_d    = cred_q;
        cnt_d     = cnt_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rd_err_d  = rd_err_q;
        if (ar_hs) begin
            araddr_d  = {m_al_araddr, {LSB{1'b0}}};
            arvalid_d = 1'b1;
        end else if (s_axi_arready) begin
            arvalid_d = 1'b0;
        end
        if (ar_hs && !r_pop) cred_d = cred_q + CW'(1);
        if (!ar_hs && r_pop) cred_d = cred_q - CW'(1);
        if (r_push && !r_pop) cnt_d = cnt_q + CW'(1);
        if (!r_push && r_pop) cnt_d = cnt_q - CW'(1);
        if (r_push) wptr_d = (wptr_q == LAST_C) ? '0 : wptr_q + PW'(1);
        if (r_pop)  rptr_d = (rptr_q == LAST_C) ? '0 : rptr_q + PW'(1);
        if (r_push && s_axi_rresp != 2'b00 && rd_err_q != 16'hFFFF) rd_err_d = rd_err_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            cred_q    <= '0;
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_err_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            cred_q    <= cred_d;
            cnt_q     <= cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rd_err_q  <= rd_err_d;
            if (r_push) mem_q[wptr_q] <= {s_axi_rresp, s_axi_rdata};
        end
    end

    assign s_axi_araddr  = araddr_q;
    assign s_axi_arvalid = arvalid_q;
    assign s_axi_rready  = 1'b1;
    assign m_al_rvalid   = (cnt_q != '0);
    assign {m_al_rresp, m_al_rdata} = mem_q[rptr_q];
    assign rd_err_cnt    = rd_err_q;

endmodule
